// File: rtl/bus_arbiter_if.sv
// Shared-bus handshake bundle between the bus masters and the round-robin arbiter.
// The slave modport is the arbiter's view; the master modport is the bus side.
interface bus_arbiter_if #(
    parameter int NR_MASTERS = 4
);
    logic [NR_MASTERS-1:0] bus_request;
    logic [NR_MASTERS-1:0] bus_aquire;
    logic                  begin_transaction_in;
    logic                  end_transaction_in;
    logic                  end_transaction_out;
    logic                  bus_error;
    logic                  bus_idle;

    modport master (
        output bus_request,
        output begin_transaction_in,
        output end_transaction_in,
        input  bus_aquire,
        input  end_transaction_out,
        input  bus_error,
        input  bus_idle
    );

    modport slave (
        input  bus_request,
        input  begin_transaction_in,
        input  end_transaction_in,
        output bus_aquire,
        output end_transaction_out,
        output bus_error,
        output bus_idle
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with an unused-grant watchdog and a hung-transaction
// watchdog that aborts with a one-cycle bus_error and a forced end pulse.
module bus_arbiter #(
    parameter int NR_MASTERS    = 4,
    parameter int GRANT_TIMEOUT = 16,
    parameter int BUS_TIMEOUT   = 256
) (
    input  logic            clock,
    input  logic            reset,
    bus_arbiter_if.slave    bus
);
    localparam int MAX_TIMEOUT = (GRANT_TIMEOUT > BUS_TIMEOUT) ? GRANT_TIMEOUT : BUS_TIMEOUT;
    localparam int CNT_W       = $clog2(MAX_TIMEOUT) + 1;
    localparam int IDX_W       = (NR_MASTERS > 1) ? $clog2(NR_MASTERS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GRANTED,
        TRANSACT,
        ABORT
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      rr_q, rr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NR_MASTERS-1:0] grant_q, grant_d;
    logic                  error_q, error_d;
    logic                  end_out_q, end_out_d;
    logic                  idle_q, idle_d;

    logic                  sel_valid;
    logic [IDX_W-1:0]      sel_idx;
    logic [IDX_W-1:0]      cand_idx;
    logic [CNT_W-1:0]      cnt_inc;
    logic                  owner_requesting;

    // First requester found scanning upward from the master after the last winner.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int i = 1; i <= NR_MASTERS; i++) begin
            cand_idx = IDX_W'((int'(rr_q) + i) % NR_MASTERS);
            if (!sel_valid && bus.bus_request[cand_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    assign cnt_inc          = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign owner_requesting = |(bus.bus_request & grant_q);

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        cnt_d     = cnt_inc;
        grant_d   = grant_q;
        error_d   = 1'b0;
        end_out_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (sel_valid) begin
                    state_d = GRANTED;
                    grant_d = NR_MASTERS'(1) << sel_idx;
                    rr_d    = sel_idx;
                end
            end
            GRANTED: begin
                // begin beats a dropped request, which beats the grant timeout
                if (bus.begin_transaction_in) begin
                    state_d = TRANSACT;
                    cnt_d   = '0;
                end else if (!owner_requesting || cnt_q == CNT_W'(GRANT_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end
            end
            TRANSACT: begin
                if (bus.end_transaction_in) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(BUS_TIMEOUT - 1)) begin
                    state_d   = ABORT;
                    grant_d   = '0;
                    cnt_d     = '0;
                    error_d   = 1'b1;
                    end_out_d = 1'b1;
                end
            end
            ABORT: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign idle_d = (state_d == IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rr_q      <= IDX_W'(NR_MASTERS - 1);
            cnt_q     <= '0;
            grant_q   <= '0;
            error_q   <= 1'b0;
            end_out_q <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            error_q   <= error_d;
            end_out_q <= end_out_d;
            idle_q    <= idle_d;
        end
    end

    assign bus.bus_aquire          = grant_q;
    assign bus.bus_error           = error_q;
    assign bus.end_transaction_out = end_out_q;
    assign bus.bus_idle            = idle_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes predicted grant episodes from
// a round-robin reference model, a negedge monitor pops and compares them.
module tb_bus_arbiter;
    localparam int NM = 4;
    localparam int GT = 16;
    localparam int BT = 8;

    typedef struct {
        int start;
        int master;
        int len;
        bit err;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   model_rr;
    exp_t exp_q[$];

    bus_arbiter_if #(.NR_MASTERS(NM)) bus ();

    bus_arbiter #(
        .NR_MASTERS    (NM),
        .GRANT_TIMEOUT (GT),
        .BUS_TIMEOUT   (BT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(string name, int actual, int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference arbitration: first requester after the last winner, wrapping around.
    function automatic int pick(int rr, logic [NM-1:0] m);
        for (int i = 1; i <= NM; i++) begin
            int c = (rr + i) % NM;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    task automatic expect_grant(logic [NM-1:0] m, int len, bit err, output int sel);
        exp_t e;
        sel      = pick(model_rr, m);
        model_rr = sel;
        e.start  = cyc + 1;
        e.master = sel;
        e.len    = len;
        e.err    = err;
        exp_q.push_back(e);
    endtask

    task automatic run_normal(logic [NM-1:0] m, int k, int lm, bit drop, bit spur);
        int sel;
        expect_grant(m, k + lm + 2, 1'b0, sel);
        bus.bus_request = m;
        tick();
        repeat (k) tick();
        bus.begin_transaction_in = 1'b1;
        if (drop) bus.bus_request = m & ~(NM'(1) << sel);
        tick();
        bus.begin_transaction_in = spur;
        repeat (lm) begin
            tick();
            bus.begin_transaction_in = 1'b0;
        end
        bus.end_transaction_in = 1'b1;
        tick();
        bus.end_transaction_in   = 1'b0;
        bus.begin_transaction_in = 1'b0;
    endtask

    task automatic run_timeout(logic [NM-1:0] m);
        int sel;
        expect_grant(m, GT, 1'b0, sel);
        bus.bus_request = m;
        tick();
        repeat (GT) tick();
    endtask

    task automatic run_drop(logic [NM-1:0] m, int k);
        int sel;
        expect_grant(m, k + 1, 1'b0, sel);
        bus.bus_request = m;
        tick();
        repeat (k) tick();
        bus.bus_request = m & ~(NM'(1) << sel);
        tick();
    endtask

    task automatic run_hang(logic [NM-1:0] m, int k);
        int sel;
        expect_grant(m, k + 1 + BT, 1'b1, sel);
        bus.bus_request = m;
        tick();
        repeat (k) tick();
        bus.begin_transaction_in = 1'b1;
        tick();
        bus.begin_transaction_in = 1'b0;
        repeat (BT) tick();
        tick();
    endtask

    task automatic run_idle(int r);
        bus.bus_request = '0;
        repeat (r) tick();
    endtask

    // Asynchronous reset dropped between edges while a transaction is running.
    task automatic run_reset(logic [NM-1:0] m, int k, int j);
        int sel;
        expect_grant(m, -1, 1'b0, sel);
        bus.bus_request = m;
        tick();
        repeat (k) tick();
        bus.begin_transaction_in = 1'b1;
        tick();
        bus.begin_transaction_in = 1'b0;
        repeat (j) tick();
        #2 reset = 1'b0;
        #1;
        check_output("reset_mid_aquire", int'(bus.bus_aquire), 0);
        check_output("reset_mid_error", int'(bus.bus_error), 0);
        check_output("reset_mid_end_out", int'(bus.end_transaction_out), 0);
        check_output("reset_mid_idle", int'(bus.bus_idle), 1);
        bus.bus_request = '0;
        @(negedge clock);
        #2 reset = 1'b1;
        model_rr = NM - 1;
        tick();
    endtask

    task automatic apply_stimulus();
        int kind;
        logic [NM-1:0] m;
        // fairness: held 4'b1011 with 3-cycle grants gives 0,1,3,0,1,3
        repeat (6) run_normal(4'b1011, 0, 1, 1'b0, 1'b0);
        run_normal(4'b0001, 1, 4, 1'b0, 1'b0);
        run_timeout(4'b0100);
        run_normal(4'b0100, 2, 3, 1'b0, 1'b0);
        run_hang(4'b0010, 1);
        run_normal(4'b1000, 0, BT - 1, 1'b0, 1'b0);
        run_normal(4'b0110, GT - 1, 2, 1'b1, 1'b1);
        run_drop(4'b0011, 3);
        run_reset(4'b0100, 1, 2);
        run_normal(4'b1111, 0, 2, 1'b0, 1'b0);
        run_idle(2);
        for (int e = 0; e < 60; e++) begin
            m    = NM'($urandom_range(15, 1));
            kind = $urandom_range(9, 0);
            case (kind)
                5:       run_timeout(m);
                6:       run_drop(m, $urandom_range(GT - 1, 0));
                7:       run_hang(m, $urandom_range(GT - 1, 0));
                8:       run_idle($urandom_range(3, 1));
                9:       run_reset(m, $urandom_range(GT - 1, 0), $urandom_range(BT - 1, 0));
                default: run_normal(m, $urandom_range(GT - 1, 0), $urandom_range(BT - 1, 0),
                                    ($urandom_range(2, 0) == 0), 1'($urandom_range(1, 0)));
            endcase
        end
        run_idle(5);
    endtask

    bit   in_grant  = 1'b0;
    bit   prev_idle = 1'b1;
    int   start_cyc = 0;
    exp_t cur;

    always @(negedge clock) begin
        if (!reset) begin
            in_grant  = 1'b0;
            prev_idle = 1'b1;
        end else begin
            if (!in_grant && bus.bus_aquire != '0) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_grant", int'(bus.bus_aquire), 0);
                end else begin
                    cur       = exp_q.pop_front();
                    in_grant  = 1'b1;
                    start_cyc = cyc;
                    check_output("grant_cycle", cyc, cur.start);
                    check_output("grant_master", int'(bus.bus_aquire), 1 << cur.master);
                    check_output("idle_before_grant", int'(prev_idle), 1);
                    check_output("idle_during_grant", int'(bus.bus_idle), 0);
                end
            end else if (in_grant && bus.bus_aquire != '0) begin
                check_output("grant_hold", int'(bus.bus_aquire), 1 << cur.master);
                check_output("error_during_grant", int'(bus.bus_error), 0);
            end else if (in_grant) begin
                in_grant = 1'b0;
                check_output("grant_length", cyc - start_cyc, cur.len);
                check_output("release_error", int'(bus.bus_error), int'(cur.err));
                check_output("release_end_out", int'(bus.end_transaction_out), int'(cur.err));
                check_output("release_idle", int'(bus.bus_idle), int'(!cur.err));
            end else begin
                check_output("stray_error", int'(bus.bus_error), 0);
                check_output("stray_end_out", int'(bus.end_transaction_out), 0);
                check_output("idle_level", int'(bus.bus_idle), 1);
            end
            prev_idle = bus.bus_idle;
        end
    end

    initial begin
        reset                    = 1'b0;
        model_rr                 = NM - 1;
        bus.bus_request          = '0;
        bus.begin_transaction_in = 1'b0;
        bus.end_transaction_in   = 1'b0;
        tick();
        check_output("reset_aquire", int'(bus.bus_aquire), 0);
        check_output("reset_error", int'(bus.bus_error), 0);
        check_output("reset_end_out", int'(bus.end_transaction_out), 0);
        check_output("reset_idle", int'(bus.bus_idle), 1);
        tick();
        #3 reset = 1'b1;
        tick();
        apply_stimulus();
        check_output("pending_expectations", exp_q.size(), 0);
        check_output("grant_left_open", int'(in_grant), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
